// File: rtl/lm32_ram_pkg.sv
// Shared definitions for the lm32_ram_be byte-enable RAM: state encoding,
// lane-count helper and the per-lane merge used by the write and bypass paths.
package lm32_ram_pkg;

  typedef enum logic {
    LM32_RAM_ST_INIT = 1'b0,
    LM32_RAM_ST_RUN  = 1'b1
  } lm32_ram_state_e;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int LM32_RAM_MAX_W = 1024;

  function automatic int NB(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic logic [LM32_RAM_MAX_W-1:0] lane_merge(
    input logic [LM32_RAM_MAX_W-1:0] old_word,
    input logic [LM32_RAM_MAX_W-1:0] new_word,
    input logic [LM32_RAM_MAX_W-1:0] be,
    input int                        byte_width
  );
    logic [LM32_RAM_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < LM32_RAM_MAX_W; i++) begin
      if (be[i / byte_width]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lm32_ram_init_ctrl.sv
// Post-reset initialisation sweep for lm32_ram_be: walks every word once,
// presenting an address and write strobe, then parks in RUN until reset.
module lm32_ram_init_ctrl
  import lm32_ram_pkg::*;
#(
  parameter int address_width = 10,
  parameter int depth         = 1 << address_width
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  output logic [address_width-1:0] sweep_addr,
  output logic                     sweep_we,
  output logic                     init_busy
);

  localparam logic [address_width-1:0] LAST_ADDR = address_width'(depth - 1);

  lm32_ram_state_e          state_q, state_d;
  logic [address_width-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= LM32_RAM_ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == LM32_RAM_ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = LM32_RAM_ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  assign sweep_addr = cnt_q;
  assign sweep_we   = (state_q == LM32_RAM_ST_INIT);
  assign init_busy  = (state_q == LM32_RAM_ST_INIT);

endmodule

// File: rtl/lm32_ram_be.sv
// Pseudo dual-port RAM with byte-lane writes, registered read + valid and a
// self-init sweep. Define LM32_RAM_BYPASS_EN for write-first same-address reads.
module lm32_ram_be
  import lm32_ram_pkg::*;
#(
  parameter int                  data_width    = 32,
  parameter int                  byte_width    = 8,
  parameter int                  address_width = 10,
  parameter int                  depth         = 1 << address_width,
  parameter logic [data_width-1:0] init_value  = '0
) (
  input  logic                                       clk_i,
  input  logic                                       rst_n_i,
  input  logic                                       enable_read,
  input  logic [address_width-1:0]                   read_address,
  input  logic                                       enable_write,
  input  logic [address_width-1:0]                   write_address,
  input  logic [data_width-1:0]                      write_data,
  input  logic [NB(data_width, byte_width)-1:0]      write_byte_enable,
  output logic [data_width-1:0]                      read_data,
  output logic                                       read_valid,
  output logic                                       init_busy
);

  localparam int                     IDX_W   = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [address_width:0] DEPTH_C = (address_width + 1)'(depth);

  function automatic logic [data_width-1:0] merge_w(
    input logic [data_width-1:0]                 old_w,
    input logic [data_width-1:0]                 new_w,
    input logic [NB(data_width, byte_width)-1:0] be
  );
    logic [LM32_RAM_MAX_W-1:0] m;
    m = lane_merge(LM32_RAM_MAX_W'(old_w), LM32_RAM_MAX_W'(new_w),
                   LM32_RAM_MAX_W'(be), byte_width);
    return m[data_width-1:0];
  endfunction

  logic [data_width-1:0]    mem [depth];
  logic [address_width-1:0] sweep_addr;
  logic                     sweep_we;

  lm32_ram_init_ctrl #(
    .address_width(address_width),
    .depth        (depth)
  ) u_init_ctrl (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .sweep_addr(sweep_addr),
    .sweep_we  (sweep_we),
    .init_busy (init_busy)
  );

  logic                  wr_in_range, rd_in_range, collide;
  logic [IDX_W-1:0]      wa_idx, ra_idx, wr_idx;
  logic                  wr_en;
  logic [data_width-1:0] wr_word, rd_stored, rd_word;

  assign wr_in_range = ({1'b0, write_address} < DEPTH_C);
  assign rd_in_range = ({1'b0, read_address} < DEPTH_C);
  assign wa_idx      = write_address[IDX_W-1:0];
  assign ra_idx      = read_address[IDX_W-1:0];
  assign rd_stored   = mem[ra_idx];
  assign collide     = enable_write && (write_address == read_address);

  // The sweep owns the write port while busy; out-of-range writes vanish.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = wa_idx;
    wr_word = init_value;
    if (sweep_we) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_addr[IDX_W-1:0];
      wr_word = init_value;
    end else if (enable_write && wr_in_range && (|write_byte_enable)) begin
      wr_en   = 1'b1;
      wr_word = merge_w(mem[wa_idx], write_data, write_byte_enable);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

`ifdef LM32_RAM_BYPASS_EN
  assign rd_word = collide ? merge_w(rd_stored, write_data, write_byte_enable) : rd_stored;
`else
  logic unused_collide;
  assign unused_collide = collide;
  assign rd_word        = rd_stored;
`endif

  logic [data_width-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;

  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    if (!init_busy && enable_read) begin
      read_valid_d = 1'b1;
      read_data_d  = rd_in_range ? rd_word : init_value;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_lm32_ram_be.sv
// Scoreboard bench for lm32_ram_be (32-bit data, 8-bit lanes, depth 12 of 16,
// init_value DEADBEEF); reads push expectations, a negedge monitor pops them.
module tb_lm32_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_read, enable_write;
  logic [3:0]  read_address, write_address;
  logic [31:0] write_data;
  logic [3:0]  write_byte_enable;
  logic [31:0] read_data;
  logic        read_valid, init_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] IV = 32'hDEAD_BEEF;
`ifdef LM32_RAM_BYPASS_EN
  localparam logic [31:0] COLLIDE_EXP = 32'hDEAD_CCDD;
`else
  localparam logic [31:0] COLLIDE_EXP = 32'hDEAD_BEEF;
`endif

  always #5 clk = ~clk;

  lm32_ram_be #(
    .data_width(32), .byte_width(8), .address_width(4), .depth(12),
    .init_value(32'hDEAD_BEEF)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .enable_read      (enable_read),
    .read_address     (read_address),
    .enable_write     (enable_write),
    .write_address    (write_address),
    .write_data       (write_data),
    .write_byte_enable(write_byte_enable),
    .read_data        (read_data),
    .read_valid       (read_valid),
    .init_busy        (init_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid read must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got %h expected no read", read_data);
      end else begin
        check("scoreboard_read", read_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    enable_write = 1'b1; write_address = a; write_data = d; write_byte_enable = be;
    tick();
    enable_write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
    enable_read = 1'b1; read_address = a;
    exp_q.push_back(exp);
    tick();
    enable_read = 1'b0;
    check("read_valid_latency", {31'b0, read_valid}, 32'd1);
  endtask

  task automatic wait_init(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    do begin
      tick();
      n++;
      if (read_valid) saw_valid = 1'b1;
    end while (init_busy && n < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  sv;
    rst_n = 1'b0;
    enable_read = 1'b1; read_address = 4'd5;
    enable_write = 1'b0; write_address = '0; write_data = '0; write_byte_enable = '0;
    #3;
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_valid", {31'b0, read_valid}, 32'd0);
    check("reset_init_busy", {31'b0, init_busy}, 32'd1);

    // Sweep length with a read held pending the whole time.
    @(negedge clk) rst_n = 1'b1;
    wait_init(n, sv);
    check("init_edges", n, 32'd12);
    check("init_no_valid", {31'b0, sv}, 32'd0);
    exp_q.push_back(IV);
    tick();
    enable_read = 1'b0;
    check("first_run_valid", {31'b0, read_valid}, 32'd1);

    // Byte-lane write.
    do_write(4'd3, 32'h1122_3344, 4'b0101);
    do_read(4'd3, 32'hDE22_BE44);

    // Out-of-range and boundary addresses.
    do_write(4'd13, 32'h1234_5678, 4'hF);
    do_read(4'd13, IV);
    do_read(4'd12, IV);
    do_read(4'd1, IV);
    do_write(4'd11, 32'hCAFE_F00D, 4'hF);
    do_read(4'd11, 32'hCAFE_F00D);
    do_write(4'd1, 32'h0BAD_0BAD, 4'h0);
    do_read(4'd1, IV);

    // Same-address collision, then the landed write.
    enable_write = 1'b1; write_address = 4'd7; write_data = 32'hAABB_CCDD; write_byte_enable = 4'b0011;
    do_read(4'd7, COLLIDE_EXP);
    enable_write = 1'b0;
    do_read(4'd7, 32'hDEAD_CCDD);

    // Read then hold while writing the same word.
    do_read(4'd4, IV);
    for (int i = 0; i < 3; i++) begin
      enable_write = 1'b1; write_address = 4'd4; write_data = 32'h5566_7788; write_byte_enable = 4'hF;
      tick();
      check("hold_valid_low", {31'b0, read_valid}, 32'd0);
      check("hold_data", read_data, IV);
    end
    enable_write = 1'b0;
    do_read(4'd4, 32'h5566_7788);

    // Asynchronous reset from RUN, then again mid-sweep at count 6.
    do_read(4'd3, 32'hDE22_BE44);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", read_data, 32'h0);
    check("async_rst_busy", {31'b0, init_busy}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midsweep_busy", {31'b0, init_busy}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    enable_write = 1'b1; write_address = 4'd2; write_data = 32'h0; write_byte_enable = 4'hF;
    wait_init(n, sv);
    enable_write = 1'b0;
    check("restart_edges", n, 32'd12);
    check("restart_no_valid", {31'b0, sv}, 32'd0);
    do_read(4'd2, IV);
    do_read(4'd3, IV);
    do_read(4'd7, IV);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
